// File: rtl/spongent_squeeze_if.sv
// Handshake bundle between the Spongent squeeze engine and its block/hash consumer.
// master drives start/absorbed_state/block_ready; slave is the squeeze engine.
interface spongent_squeeze_if #(
  parameter int N = 88,
  parameter int b = 88,
  parameter int r = 8
);
  logic         start;
  logic [b-1:0] absorbed_state;
  logic         idle;
  logic [r-1:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [N-1:0] hash_out;
  logic         hash_valid;

  modport master (
    output start, absorbed_state, block_ready,
    input  idle, block_out, block_valid, hash_out, hash_valid
  );

  modport slave (
    input  start, absorbed_state, block_ready,
    output idle, block_out, block_valid, hash_out, hash_valid
  );
endinterface

// File: rtl/spongent_squeeze.sv
// Spongent squeeze phase: emits K rate blocks, one permutation (R rounds, one per
// cycle) between consecutive blocks, and assembles them into an N-bit hash.
module spongent_squeeze #(
  parameter int N       = 88,
  parameter int c       = 80,
  parameter int r       = 8,
  parameter int R       = 45,
  parameter int LC_INIT = 6'h05,
  parameter int LC_TAPS = 6'h30
) (
  input  logic               clk,
  input  logic               rst,
  spongent_squeeze_if.slave  bus
);

  localparam int b  = c + r;
  localparam int W  = $clog2(R);
  localparam int K  = N / r;
  localparam int JW = (K > 1) ? $clog2(K) : 1;
  localparam int HW = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0]  LC_INIT_W = W'(LC_INIT);
  localparam logic [W-1:0]  LC_TAPS_W = W'(LC_TAPS);
  localparam logic [W-1:0]  RND_LAST  = W'(R - 1);
  localparam logic [JW-1:0] J_LAST    = JW'(K - 1);

  if ((N % r) != 0 || (b % 4) != 0 || W < 2) begin : g_bad_params
    $error("spongent_squeeze: N must be a multiple of r, b a multiple of 4, and R >= 3");
  end

  typedef enum logic [1:0] {IDLE, EMIT, PERM, DONE} fsm_e;

  fsm_e          st_q, st_d;
  logic [b-1:0]  state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [W-1:0]  rnd_q, rnd_d;
  logic [W-1:0]  lc_q, lc_d;
  logic [N-1:0]  hash_q, hash_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hE;  4'h1: sbox = 4'hD;  4'h2: sbox = 4'hB;  4'h3: sbox = 4'h0;
      4'h4: sbox = 4'h2;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h4;  4'h7: sbox = 4'hF;
      4'h8: sbox = 4'h7;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h8;  4'hB: sbox = 4'h5;
      4'hC: sbox = 4'h9;  4'hD: sbox = 4'hC;  4'hE: sbox = 4'h3;  default: sbox = 4'h6;
    endcase
  endfunction

  // One permutation round as pure wiring: counter injection, S-box layer, bit permutation.
  logic [W-1:0] lc_rev;
  logic [b-1:0] rc_in, sb_out, round_out;

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign lc_rev[i] = lc_q[W-1-i];
  end

  assign rc_in = state_q ^ {{(b-W){1'b0}}, lc_q} ^ {lc_rev, {(b-W){1'b0}}};

  for (genvar k = 0; k < b/4; k++) begin : g_sbox
    assign sb_out[4*k +: 4] = sbox(rc_in[4*k +: 4]);
  end

  for (genvar i = 0; i < b-1; i++) begin : g_play
    assign round_out[(i*b/4) % (b-1)] = sb_out[i];
  end
  assign round_out[b-1] = sb_out[b-1];

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    j_d     = j_q;
    rnd_d   = rnd_q;
    lc_d    = lc_q;
    hash_d  = hash_q;
    case (st_q)
      IDLE: begin
        if (bus.start) begin
          state_d = bus.absorbed_state;
          j_d     = '0;
          st_d    = EMIT;
        end
      end
      EMIT: begin
        if (bus.block_ready) begin
          for (int k = 0; k < K; k++) begin
            if (j_q == JW'(k)) hash_d[HW'(N-1-k*r) -: r] = state_q[r-1:0];
          end
          if (j_q == J_LAST) begin
            st_d = DONE;
          end else begin
            j_d   = j_q + 1'b1;
            rnd_d = '0;
            lc_d  = LC_INIT_W;
            st_d  = PERM;
          end
        end
      end
      PERM: begin
        state_d = round_out;
        lc_d    = {lc_q[W-2:0], ^(lc_q & LC_TAPS_W)};
        if (rnd_q == RND_LAST) st_d = EMIT;
        else                   rnd_d = rnd_q + 1'b1;
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the wide state register is cleared on reset too, so block_out reads 0 after any abort.
      st_q    <= IDLE;
      state_q <= '0;
      j_q     <= '0;
      rnd_q   <= '0;
      lc_q    <= '0;
      hash_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      j_q     <= j_d;
      rnd_q   <= rnd_d;
      lc_q    <= lc_d;
      hash_q  <= hash_d;
    end
  end

  assign bus.idle        = (st_q == IDLE);
  assign bus.block_valid = (st_q == EMIT);
  assign bus.block_out   = (st_q == EMIT) ? state_q[r-1:0] : '0;
  assign bus.hash_out    = hash_q;
  assign bus.hash_valid  = (st_q == DONE);

endmodule

// File: tb/tb_spongent_squeeze.sv
// Directed bench for spongent_squeeze: vector table of full squeezes against a
// Spongent-88 reference model, plus reset-abort, single-round and K==1 sequences.
module tb_spongent_squeeze;

  localparam logic [3:0] SBOX [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                       4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  spongent_squeeze_if #(.N(88), .b(88), .r(8)) bus ();
  spongent_squeeze_if #(.N(8),  .b(88), .r(8)) bus1 ();

  spongent_squeeze dut (.clk(clk), .rst(rst), .bus(bus));
  spongent_squeeze #(.N(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [87:0] abs_v;
    int          stall_blk;
    int          stall_len;
    bit          repulse;
    int          exp_lat;
    logic [87:0] exp_hash;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model, written from the algorithm description.
  function automatic logic [87:0] m_round(input logic [87:0] s, input logic [5:0] lc);
    logic [87:0] t, u, p;
    t = s ^ {82'b0, lc} ^ {lc[0], lc[1], lc[2], lc[3], lc[4], lc[5], 82'b0};
    for (int n = 0; n < 22; n++) u[7'(4*n) +: 4] = SBOX[t[7'(4*n) +: 4]];
    p = '0;
    for (int i = 0; i < 87; i++) p[7'((i*22) % 87)] = u[7'(i)];
    p[87] = u[87];
    return p;
  endfunction

  function automatic logic [87:0] m_hash(input logic [87:0] a);
    logic [87:0] s, h;
    logic [5:0]  lc;
    s = a;
    h = '0;
    for (int j = 0; j < 11; j++) begin
      h = {h[79:0], s[7:0]};
      if (j < 10) begin
        lc = 6'h05;
        for (int q = 0; q < 45; q++) begin
          s  = m_round(s, lc);
          lc = {lc[4:0], lc[5] ^ lc[4]};
        end
      end
    end
    return h;
  endfunction

  task automatic run_op(input logic [87:0] abs_v, input int stall_blk, input int stall_len,
                        input bit repulse, output int lat, output int nblk, output int pulses,
                        output logic [87:0] h, output logic [7:0] blk0, output bit stable_ok,
                        output logic [87:0] h_at_start);
    int cyc, left, done_cyc;
    logic [7:0] held;
    lat = 0; nblk = 0; pulses = 0; h = '0; blk0 = '0; stable_ok = 1'b1;
    done_cyc = -1; left = stall_len; held = '0;
    @(negedge clk);
    bus.absorbed_state = abs_v;
    bus.start          = 1'b1;
    bus.block_ready    = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    h_at_start = bus.hash_out;
    cyc = 1;
    while (cyc < 2000 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
      bus.start = repulse && (cyc == 10 || cyc == 200);
      if (bus.hash_valid) begin
        pulses++;
        if (done_cyc < 0) begin
          lat = cyc; h = bus.hash_out; done_cyc = cyc;
        end
      end
      if (bus.block_valid) begin
        if (nblk == stall_blk && left > 0) begin
          if (left == stall_len) held = bus.block_out;
          else if (bus.block_out !== held) stable_ok = 1'b0;
          left--;
          bus.block_ready = 1'b0;
        end else begin
          if (nblk == stall_blk && stall_len > 0 && bus.block_out !== held) stable_ok = 1'b0;
          if (nblk == 0) blk0 = bus.block_out;
          bus.block_ready = 1'b1;
          nblk++;
        end
      end else begin
        if (nblk == stall_blk && left > 0 && left < stall_len) stable_ok = 1'b0;
        bus.block_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.block_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nblk, pulses, cnt;
    bit stable_ok;
    logic [87:0] h, h0, prev_hash, rnd_abs;
    logic [95:0] r96;
    logic [7:0]  blk0;

    rst = 1'b0;
    bus.start = 1'b0;  bus.absorbed_state = '0;  bus.block_ready = 1'b1;
    bus1.start = 1'b0; bus1.absorbed_state = '0; bus1.block_ready = 1'b1;

    vecs[0] = '{88'h0, -1, 0, 1'b0, 462, '0};
    vecs[1] = '{88'h0,  3, 5, 1'b0, 467, '0};
    vecs[2] = '{88'h0, -1, 0, 1'b1, 462, '0};
    vecs[3] = '{88'h0123456789ABCDEFFEDCBA, 0, 2, 1'b0, 464, '0};
    vecs[4] = '{{88{1'b1}}, 10, 3, 1'b0, 465, '0};
    foreach (vecs[i]) vecs[i].exp_hash = m_hash(vecs[i].abs_v);

    repeat (3) @(posedge clk);
    #1;
    check("reset_idle",        bus.idle,        1'b1);
    check("reset_block_valid", bus.block_valid, 1'b0);
    check("reset_hash_valid",  bus.hash_valid,  1'b0);
    check("reset_hash_out",    bus.hash_out,    88'h0);
    check("reset_block_out",   bus.block_out,   8'h00);
    @(negedge clk);
    rst = 1'b1;

    prev_hash = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].abs_v, vecs[i].stall_blk, vecs[i].stall_len, vecs[i].repulse,
             lat, nblk, pulses, h, blk0, stable_ok, h0);
      check($sformatf("v%0d_hash_kept_on_start", i), h0, prev_hash);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_blocks", i), nblk, 11);
      check($sformatf("v%0d_valid_pulses", i), pulses, 1);
      check($sformatf("v%0d_block0", i), blk0, vecs[i].abs_v[7:0]);
      check($sformatf("v%0d_hash", i), h, vecs[i].exp_hash);
      check($sformatf("v%0d_hash_msb", i), h[87:80], vecs[i].abs_v[7:0]);
      if (vecs[i].stall_len > 0) check($sformatf("v%0d_stall_stable", i), stable_ok, 1'b1);
      check($sformatf("v%0d_hash_held", i), bus.hash_out, vecs[i].exp_hash);
      check($sformatf("v%0d_idle_after", i), bus.idle, 1'b1);
      prev_hash = vecs[i].exp_hash;
    end

    // Single round from state 0 with lCounter 0x05.
    @(negedge clk);
    bus.absorbed_state = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("round1_state", dut.state_q, m_round(88'h0, 6'h05));
    check("round1_lc", dut.lc_q, 6'h0A);
    cnt = 0;
    while (cnt < 1000 && !bus.hash_valid) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("round1_run_done", bus.hash_valid, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of a permutation aborts the run.
    @(negedge clk);
    bus.absorbed_state = 88'hDEADBEEF0123456789ABCD;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", bus.idle, 1'b1);
    check("abort_hash_cleared", bus.hash_out, 88'h0);
    check("abort_block_valid", bus.block_valid, 1'b0);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (bus.hash_valid) pulses++;
    end
    check("abort_no_hash_valid", pulses, 0);
    r96 = {$urandom, $urandom, $urandom};
    rnd_abs = r96[87:0];
    run_op(rnd_abs, -1, 0, 1'b0, lat, nblk, pulses, h, blk0, stable_ok, h0);
    check("fresh_latency", lat, 462);
    check("fresh_pulses", pulses, 1);
    check("fresh_hash", h, m_hash(rnd_abs));

    // K == 1: one block, straight from EMIT to DONE.
    @(negedge clk);
    bus1.absorbed_state = 88'h1122334455667788990AA5;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    check("k1_block_valid", bus1.block_valid, 1'b1);
    check("k1_block_out", bus1.block_out, 8'hA5);
    @(posedge clk); #1;
    check("k1_hash_valid", bus1.hash_valid, 1'b1);
    check("k1_hash_out", bus1.hash_out, 8'hA5);
    @(posedge clk); #1;
    check("k1_idle", bus1.idle, 1'b1);
    check("k1_hash_valid_drop", bus1.hash_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spongent_squeeze.md
SPONGENT_SQUEEZE -- requirements
Module: spongent_squeeze

Interface
REQ-001 Parameter N, default 88: hash length in bits.
REQ-002 Parameter c, default 80: capacity in bits.
REQ-003 Parameter r, default 8: rate in bits, one output block.
REQ-004 Parameter R, default 45: permutation rounds.
REQ-005 Parameter LC_INIT, default 6'h05: lCounter value at round 0.
REQ-006 Parameter LC_TAPS, default 6'h30: lCounter feedback mask.
REQ-007 Derived values: b=c+r; W=$clog2(R); K=N/r; N%r==0 and b%4==0 are required, elaboration error otherwise.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst  input  1  synchronous, active-low reset.
REQ-010 start  input  1  request squeeze of absorbed_state.
REQ-011 absorbed_state  input  b  sponge state after the absorbing phase.
REQ-012 idle  output  1  high only in IDLE; start is accepted.
REQ-013 block_out  output  r  current squeezed block.
REQ-014 block_valid  output  1  block_out is valid.
REQ-015 block_ready  input  1  consumer accepts block_out.
REQ-016 hash_out  output  N  complete hash.
REQ-017 hash_valid  output  1  one-cycle pulse when hash_out updates.

Function
REQ-018 FSM states: IDLE, EMIT, PERM, DONE; state, block index j (0..K-1), round counter (0..R-1) and lCounter (W bits) are registered.
REQ-019 IDLE: start=1 loads absorbed_state into the state register, clears j, goes to EMIT; start in any other state is ignored.
REQ-020 EMIT: block_valid=1; block_out=state[r-1:0]; block_out is held stable while block_ready=0.
REQ-021 EMIT with block_ready=1: block written to hash_out[N-1-j*r -: r] (block 0 lands in the MSBs). If j==K-1, next state is DONE. Otherwise j increments, round counter clears, lCounter loads LC_INIT, next state is PERM.
REQ-022 PERM: one round per cycle; after round R-1, next state is EMIT; the state register is untouched in every other FSM state.
REQ-023 Round step 1: state ^= zero-extended lCounter, XORed into bits W-1:0.
REQ-024 Round step 2: state ^= bit-reverse(lCounter) << (b-W).
REQ-025 Round step 3: each nibble passes through S-box 0..F -> E,D,B,0,2,1,4,F,7,A,8,5,9,C,3,6.
REQ-026 Round step 4: pLayer; bit i moves to (i*b/4) mod (b-1) for i<b-1; bit b-1 is fixed.
REQ-027 lCounter update each PERM cycle: lc <= {lc[W-2:0], ^(lc & LC_TAPS)}.
REQ-028 DONE: hash_valid=1 for exactly one cycle, then IDLE.
REQ-029 hash_out holds its value from DONE until the next accepted start; it is not cleared by start.
REQ-030 Latency with block_ready tied high: hash_valid is high (K-1)*(R+1)+2 cycles after the start cycle (defaults: 462).
REQ-031 Each low cycle of block_ready extends latency by exactly one cycle; PERM is never stalled.
REQ-032 K==1: EMIT goes directly to DONE with no PERM.

Reset
REQ-033 rst=0 at a clock edge, in any state: FSM to IDLE; state register, j, round counter, lCounter and hash_out cleared to 0.
REQ-034 During reset: idle=1, block_valid=0, hash_valid=0, block_out=0.
REQ-035 Reset mid-operation aborts the operation; no hash_valid is produced; the next start begins a fresh operation.

Verification
REQ-036 Reset: hold rst=0 for 3 cycles -> idle=1, block_valid=0, hash_valid=0, hash_out=0.
REQ-037 absorbed_state=0, block_ready=1, start pulse -> 11 blocks; block 0 = 8'h00; hash_valid exactly 462 cycles after start; hash_out equals the golden Spongent-88 squeeze model.
REQ-038 block_ready=0 for 5 cycles at block 3 -> block_out and block_valid stable throughout; hash_valid at cycle 467; hash_out unchanged vs REQ-037.
REQ-039 start re-pulsed at cycles 10 and 200 of a run -> ignored; exactly one hash_valid; result matches REQ-037.
REQ-040 rst=0 at cycle 100 (mid-PERM), then a new start with random absorbed_state -> no hash_valid from the aborted run; hash matches the model for the new input.
REQ-041 Round unit check: force one PERM round from state=0 with lCounter=6'h05 -> state equals the model's single-round output.
